// File: rtl/fifo_push_arbiter.sv
// rtl/fifo_push_arbiter.sv - packet-aware round-robin arbiter driving a shared fifo_v3 push port
// Optional build macro: FIFO_PUSH_ARBITER_STATS_EN adds per-requester completed-packet counters (pkt_cnt_o).
module fifo_push_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                flush_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data_i,
  input  logic [NUM_REQ-1:0]                  req_last_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic                                fifo_full_i,
  output logic                                fifo_push_o,
  output logic [DATA_WIDTH-1:0]               fifo_data_o,
  output logic [IDX_WIDTH-1:0]                grant_idx_o,
  output logic                                locked_o
`ifdef FIFO_PUSH_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0]            pkt_cnt_o
`endif
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_WIDTH-1:0] lock_idx_q, lock_idx_d;

  logic [31:0]          cand;
  logic [IDX_WIDTH-1:0] cand_idx;
  logic [IDX_WIDTH-1:0] scan_idx;
  logic                 scan_found;
  logic [IDX_WIDTH-1:0] win_idx;
  logic                 win_valid;
  logic                 win_last;
  logic                 xfer;
  logic [IDX_WIDTH-1:0] rr_next;

  // Round-robin search: first valid requester at or above rr_ptr_q, wrapping at NUM_REQ-1.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = rr_ptr_q;
    cand       = '0;
    cand_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(rr_ptr_q) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = IDX_WIDTH'(cand);
      if (!scan_found && req_valid_i[cand_idx]) begin
        scan_found = 1'b1;
        scan_idx   = cand_idx;
      end
    end
  end

  // Winner is pinned to the lock owner inside a packet; a transfer needs a valid winner and FIFO space.
  always_comb begin
    if (state_q == LOCKED) begin
      win_idx   = lock_idx_q;
      win_valid = req_valid_i[lock_idx_q];
    end else begin
      win_idx   = scan_idx;
      win_valid = scan_found;
    end
    win_last = req_last_i[win_idx];
    xfer     = win_valid && !fifo_full_i && !flush_i && rst_ni;
    if (win_idx == IDX_WIDTH'(NUM_REQ - 1)) begin
      rr_next = '0;
    end else begin
      rr_next = win_idx + 1'b1;
    end
  end

  // Next-state logic: lock on a non-last beat, release and advance priority on a last beat.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    if (flush_i) begin
      state_d  = IDLE;
      rr_ptr_d = '0;
    end else if (xfer) begin
      if (win_last) begin
        state_d  = IDLE;
        rr_ptr_d = rr_next;
      end else begin
        state_d    = LOCKED;
        lock_idx_d = win_idx;
      end
    end
  end

  // State, priority pointer and lock owner registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // Output decode; reset forces every handshake output and the grant index to zero.
  always_comb begin
    req_ready_o = '0;
    fifo_push_o = xfer;
    if (xfer) begin
      req_ready_o[win_idx] = 1'b1;
    end
    grant_idx_o = rst_ni ? win_idx : '0;
    locked_o    = rst_ni && (state_q == LOCKED);
    fifo_data_o = req_data_i[grant_idx_o];
  end

`ifdef FIFO_PUSH_ARBITER_STATS_EN
  logic [NUM_REQ-1:0][15:0] pkt_cnt_q;

  // Saturating count of completed packets per requester, cleared by reset and flush.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      pkt_cnt_q <= '0;
    end else if (xfer && win_last && (pkt_cnt_q[win_idx] != 16'hFFFF)) begin
      pkt_cnt_q[win_idx] <= pkt_cnt_q[win_idx] + 16'd1;
    end
  end

  assign pkt_cnt_o = pkt_cnt_q;
`endif

endmodule
